// File: rtl/qsys_iface_pipe_hw.sv
// ---------------------------------------------------------------------------
// qsys_iface_pipe_hw
//
// Avalon-ST pipeline buffer. It is a show-ahead FIFO of DEPTH entries that
// sits between a streaming sink and a streaming source. A word pushed at
// clock edge N is presented on sigOut right after edge N. With both sides
// continuously ready it moves one word per cycle.
//
// Ready and valid are registered flags. They are derived from the next
// pointer values, so sigInReady has no combinational path from sigOutReady
// and sigOut has no path from sigIn.
//
// Parameters
//   WIDTH      data word width in bits (>=1)
//   DEPTH      buffer entries (power of two, >=2)
//   HOLD_LAST  1: sigOut shows the last popped word while the buffer is empty
//
// Ports
//   clock        sole clock; all state changes on the rising edge
//   reset        asynchronous, active-low reset
//   flush        synchronous discard of all buffered words
//   sigIn        sink data
//   sigInValid   sink valid
//   sigInReady   sink ready  (buffer not full)
//   sigOut       source data (head word, show-ahead)
//   sigOutValid  source valid (buffer not empty)
//   sigOutReady  source ready
//
// Optional feature, macro QSYS_IFACE_PIPE_STATS_EN:
//   fillLevel    current number of buffered words
//   stallCount   cycles with sigInValid=1 and sigInReady=0, saturating,
//                cleared by reset only
// ---------------------------------------------------------------------------
module qsys_iface_pipe_hw #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int HOLD_LAST = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         sigIn,
  input  logic                     sigInValid,
  output logic                     sigInReady,
  output logic [WIDTH-1:0]         sigOut,
  output logic                     sigOutValid,
  input  logic                     sigOutReady
`ifdef QSYS_IFACE_PIPE_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   fillLevel,
  output logic [15:0]              stallCount
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  // Storage and pointer state. The pointers carry one extra wrap bit, so
  // they count modulo 2*DEPTH and full and empty can be told apart.
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             push_s;
  logic             pop_s;
  logic [PW-1:0]    wr_nxt_s;
  logic [PW-1:0]    rd_nxt_s;
  logic             full_nxt_s;
  logic             empty_nxt_s;
  logic [WIDTH-1:0] head_s;

  // Handshakes qualify only on the registered flags. A full buffer
  // therefore only pops and an empty buffer only pushes.
  assign push_s = sigInValid & in_ready_r;
  assign pop_s  = out_valid_r & sigOutReady;

  assign head_s = mem_r[rd_ptr_r[AW-1:0]];

  // Next-pointer computation. Flush takes priority and drops any handshake
  // that happens in the same cycle.
  always_comb begin
    wr_nxt_s = wr_ptr_r;
    rd_nxt_s = rd_ptr_r;
    if (flush) begin
      wr_nxt_s = PTR_ZERO;
      rd_nxt_s = PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_nxt_s = rd_ptr_r;
      end
    end
  end

  // Full: the wrap bits differ and the index bits match. Empty: the pointers
  // are identical.
  assign full_nxt_s  = (wr_nxt_s[AW] != rd_nxt_s[AW]) &&
                       (wr_nxt_s[AW-1:0] == rd_nxt_s[AW-1:0]);
  assign empty_nxt_s = (wr_nxt_s == rd_nxt_s);

  // Pointer and handshake-flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_nxt_s;
      rd_ptr_r    <= rd_nxt_s;
      in_ready_r  <= ~full_nxt_s;
      out_valid_r <= ~empty_nxt_s;
    end
  end

  // Data storage. It has no reset because pointer state alone decides
  // which entries are live.
  always_ff @(posedge clock) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r[AW-1:0]] <= sigIn;
    end
  end

  assign sigInReady  = in_ready_r;
  assign sigOutValid = out_valid_r;

  generate
    if (HOLD_LAST != 0) begin : g_hold
      logic [WIDTH-1:0] last_r;

      // Last-popped word. A flush leaves it untouched even when a pop was
      // requested in the same cycle.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          last_r <= {WIDTH{1'b0}};
        end else if (pop_s && !flush) begin
          last_r <= head_s;
        end else begin
          last_r <= last_r;
        end
      end

      assign sigOut = out_valid_r ? head_s : last_r;
    end else begin : g_no_hold
      assign sigOut = head_s;
    end
  endgenerate

`ifdef QSYS_IFACE_PIPE_STATS_EN
  logic [PW-1:0] count_r;
  logic [15:0]   stall_r;

  // Fill level tracks the next-pointer distance. This keeps it in step with
  // the ready and valid flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= PTR_ZERO;
    end else begin
      count_r <= wr_nxt_s - rd_nxt_s;
    end
  end

  // Sink stall counter. It saturates at all-ones and flush does not clear it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_r <= 16'h0000;
    end else if (sigInValid && !in_ready_r && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'h0001;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign fillLevel  = count_r;
  assign stallCount = stall_r;
`endif

endmodule

// File: tb/tb_qsys_iface_pipe_hw.sv
// ---------------------------------------------------------------------------
// tb_qsys_iface_pipe_hw
//
// Drives two instances of the pipeline from the same inputs: one with
// HOLD_LAST=1 and one with HOLD_LAST=0. Both are checked every cycle against
// a queue-based reference model. The sequence covers directed scenarios
// first (fill, stall, full push+pop, streaming, hold-last, flush), then
// randomized traffic, then an asynchronous reset asserted mid-cycle.
// ---------------------------------------------------------------------------
module tb_qsys_iface_pipe_hw;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] sigIn = 8'h00;
  logic             sigInValid = 1'b0;
  logic             sigOutReady = 1'b0;

  logic             in_ready_h, out_valid_h, in_ready_z, out_valid_z;
  logic [WIDTH-1:0] out_h, out_z;
`ifdef QSYS_IFACE_PIPE_STATS_EN
  logic [2:0]       fill_h, fill_z;
  logic [15:0]      stall_h, stall_z;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] last_m;
  int               stall_m;

  always #5 clock = ~clock;

  qsys_iface_pipe_hw #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_LAST(1)) u_dut (
    .clock(clock), .reset(reset), .flush(flush),
    .sigIn(sigIn), .sigInValid(sigInValid), .sigInReady(in_ready_h),
    .sigOut(out_h), .sigOutValid(out_valid_h), .sigOutReady(sigOutReady)
`ifdef QSYS_IFACE_PIPE_STATS_EN
    , .fillLevel(fill_h), .stallCount(stall_h)
`endif
  );

  qsys_iface_pipe_hw #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_LAST(0)) u_dut0 (
    .clock(clock), .reset(reset), .flush(flush),
    .sigIn(sigIn), .sigInValid(sigInValid), .sigInReady(in_ready_z),
    .sigOut(out_z), .sigOutValid(out_valid_z), .sigOutReady(sigOutReady)
`ifdef QSYS_IFACE_PIPE_STATS_EN
    , .fillLevel(fill_z), .stallCount(stall_z)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_m  = 8'h00;
    stall_m = 0;
  endtask

  // Compare every output of both instances with the model's current state.
  task automatic check_outputs(input string where);
    chk({where, ".in_ready"},    in_ready_h,  q.size() != DEPTH);
    chk({where, ".out_valid"},   out_valid_h, q.size() != 0);
    chk({where, ".in_ready_h0"}, in_ready_z,  q.size() != DEPTH);
    chk({where, ".out_valid_h0"},out_valid_z, q.size() != 0);
    if (q.size() != 0) begin
      chk({where, ".head"},    out_h, q[0]);
      chk({where, ".head_h0"}, out_z, q[0]);
    end else begin
      chk({where, ".hold_last"}, out_h, last_m);
    end
`ifdef QSYS_IFACE_PIPE_STATS_EN
    chk({where, ".fill"},     fill_h,  q.size());
    chk({where, ".fill_h0"},  fill_z,  q.size());
    chk({where, ".stall"},    stall_h, stall_m);
    chk({where, ".stall_h0"}, stall_z, stall_m);
`endif
  endtask

  // One clock cycle: apply the inputs, check the outputs, advance the model.
  task automatic cycle(input string where, input logic v, input logic [WIDTH-1:0] d,
                       input logic r, input logic f);
    bit do_push, do_pop;
    sigInValid  = v;
    sigIn       = d;
    sigOutReady = r;
    flush       = f;
    check_outputs(where);
    do_push = v && (q.size() != DEPTH);
    do_pop  = r && (q.size() != 0);
    if (v && (q.size() == DEPTH) && (stall_m != 65535)) stall_m++;
    @(posedge clock);
    if (f) begin
      q.delete();
    end else begin
      if (do_pop)  last_m = q.pop_front();
      if (do_push) q.push_back(d);
    end
    @(negedge clock);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs("in_reset");
    reset = 1'b1;
    cycle("post_release", 1'b0, 8'h00, 1'b0, 1'b0);

    // Three pushes with the source stalled.
    cycle("fill", 1'b1, 8'h11, 1'b0, 1'b0);
    cycle("fill", 1'b1, 8'h22, 1'b0, 1'b0);
    cycle("fill", 1'b1, 8'h33, 1'b0, 1'b0);
    cycle("three_held", 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to DEPTH, stall the fifth push, then push and pop while full.
    cycle("fourth", 1'b1, 8'h44, 1'b0, 1'b0);
    cycle("fifth_stall", 1'b1, 8'h55, 1'b0, 1'b0);
    cycle("full_push_pop", 1'b1, 8'h66, 1'b1, 1'b0);
    cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("drained", 1'b0, 8'h00, 1'b0, 1'b0);

    // Stream 0..19 with both sides ready; the pointers wrap several times.
    for (int i = 0; i < 20; i++) begin
      cycle("stream", 1'b1, 8'(i), 1'b1, 1'b0);
    end
    cycle("stream_tail", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("stream_done", 1'b0, 8'h00, 1'b0, 1'b0);

    // Hold the last popped word; then a flush with a concurrent pop request.
    cycle("hold_push", 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle("hold_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("hold_empty", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("hold_empty", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("pre_flush", 1'b1, 8'h01, 1'b0, 1'b0);
    cycle("pre_flush", 1'b1, 8'h02, 1'b0, 1'b0);
    cycle("flush", 1'b1, 8'h03, 1'b1, 1'b1);
    cycle("post_flush", 1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic with occasional flushes.
    repeat (400) begin
      cycle("random", 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end
    cycle("random_tail", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("random_tail", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("random_tail", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("random_tail", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset asserted mid-cycle with three words buffered.
    cycle("pre_reset", 1'b1, 8'hC1, 1'b0, 1'b0);
    cycle("pre_reset", 1'b1, 8'hC2, 1'b0, 1'b0);
    cycle("pre_reset", 1'b1, 8'hC3, 1'b0, 1'b0);
    sigInValid  = 1'b0;
    sigOutReady = 1'b0;
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clock);
    check_outputs("reset_held");
    reset = 1'b1;
    cycle("after_reset", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("after_reset", 1'b1, 8'h77, 1'b1, 1'b0);
    cycle("after_reset", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("after_reset", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
